// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch associative cache: parameter
// defaults, derived widths, the controller state type and a width helper.
package ifu_pkg;

    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_NUM_SETS   = 4;
    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH = 32;

    localparam int OFFSET_W = $clog2(DEF_LINE_WIDTH / 8);
    localparam int LADDR_W  = DEF_ADDR_WIDTH - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        FLUSH
    } ifuState_e;

    function automatic int offsetWidth(input int lineWidth);
        return $clog2(lineWidth / 8);
    endfunction

endpackage

// File: rtl/ifu_plru_tree.sv
// Combinational tree-PLRU for one set: picks the fill victim (lowest invalid
// way first) and produces the tree bits after an access to accessWay.
module ifu_plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         plruIn,
    input  logic [NUM_WAYS-1:0]         validIn,
    input  logic [$clog2(NUM_WAYS)-1:0] accessWay,
    output logic [$clog2(NUM_WAYS)-1:0] victimWay,
    output logic [NUM_WAYS-2:0]         plruOut
);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [WAY_W-1:0] lruWay;

    // A node bit of 0 steers toward the lower half; each bit taken is one way-index bit, MSB first.
    always_comb begin : findLru
        logic [WAY_W-1:0] node;
        node   = '0;
        lruWay = '0;
        for (int l = 0; l < WAY_W; l++) begin
            lruWay = WAY_W'({lruWay, plruIn[node]});
            node   = (node << 1) + WAY_W'(1) + WAY_W'(plruIn[node]);
        end
    end

    always_comb begin : pickVictim
        victimWay = lruWay;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!validIn[w]) victimWay = WAY_W'(w);
        end
    end

    always_comb begin : updatePath
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] rem;
        logic             dir;
        plruOut = plruIn;
        node    = '0;
        rem     = accessWay;
        dir     = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir           = rem[WAY_W-1];
            plruOut[node] = ~dir;
            node          = (node << 1) + WAY_W'(1) + WAY_W'(dir);
            rem           = rem << 1;
        end
    end

endmodule

// File: rtl/ifu_assoc_cache.sv
// Set-associative instruction cache with tree-PLRU replacement and whole-cache flush.
// Define IFU_CACHE_PERF_CNT_EN to add saturating hit/miss counter outputs.
//
// state     | meaning
// IDLE      | ready for a request or a flush
// LOOKUP    | compare the registered request against the indexed set
// MISS_REQ  | line fill request held on the memory port
// MISS_WAIT | waiting for fill data with the requested line address
// FILL      | write victim way, then respond with the fill data
// FLUSH     | clear all valid and PLRU bits (one cycle)
module ifu_assoc_cache
    import ifu_pkg::*;
#(
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                                            Clock,
    input  logic                                            Rst,
    input  logic                                            cpu_reqValidIn,
    input  logic [ADDR_WIDTH-1:0]                           cpu_reqAddrIn,
    output logic                                            cpu_reqReadyOut,
    output logic                                            cpu_rspValidOut,
    output logic [ADDR_WIDTH-1:0]                           cpu_rspAddrOut,
    output logic [LINE_WIDTH-1:0]                           cpu_rspInsLineOut,
    output logic                                            mem_reqValidOut,
    output logic [ADDR_WIDTH-offsetWidth(LINE_WIDTH)-1:0]   mem_reqLineAddrOut,
    input  logic                                            mem_reqReadyIn,
    input  logic                                            mem_rspValidIn,
    input  logic [ADDR_WIDTH-offsetWidth(LINE_WIDTH)-1:0]   mem_rspLineAddrIn,
    input  logic [LINE_WIDTH-1:0]                           mem_rspInsLineIn,
    input  logic                                            flushIn
`ifdef IFU_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]                                     hitCntOut,
    output logic [31:0]                                     missCntOut
`endif
);
    localparam int OFF_W    = offsetWidth(LINE_WIDTH);
    localparam int LA_W     = ADDR_WIDTH - OFF_W;
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W    = LA_W - IDX_BITS;
    localparam int WAY_W    = $clog2(NUM_WAYS);

    ifuState_e state, stateNext;

    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [LA_W-1:0]       reqLine;
    logic [IDX_W-1:0]      setIdx;
    logic [TAG_W-1:0]      reqTag;
    logic                  flushPending;
    logic [LINE_WIDTH-1:0] fillLine;

    logic [TAG_W-1:0]      tagArr   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] dataArr  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   validArr [NUM_SETS];
    logic [NUM_WAYS-2:0]   plruArr  [NUM_SETS];

    logic                  hit;
    logic [WAY_W-1:0]      hitWay;
    logic [WAY_W-1:0]      victimWay;
    logic [WAY_W-1:0]      accessWay;
    logic [NUM_WAYS-2:0]   plruNext;
    logic                  rspMatch;

    assign reqLine = reqAddr[ADDR_WIDTH-1:OFF_W];
    assign setIdx  = IDX_W'(reqLine & LA_W'(NUM_SETS - 1));
    assign reqTag  = reqLine[LA_W-1:IDX_BITS];

    assign cpu_reqReadyOut    = (state == IDLE) && !flushIn && !flushPending;
    assign mem_reqValidOut    = (state == MISS_REQ);
    assign mem_reqLineAddrOut = reqLine;
    assign rspMatch           = mem_rspValidIn && (mem_rspLineAddrIn == reqLine);

    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (validArr[setIdx][w] && (tagArr[setIdx][w] == reqTag)) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
    end

    // The set cannot change between LOOKUP and FILL, so one tree instance serves both.
    assign accessWay = (state == FILL) ? victimWay : hitWay;

    ifu_plru_tree #(.NUM_WAYS(NUM_WAYS)) uPlruTree (
        .plruIn    (plruArr[setIdx]),
        .validIn   (validArr[setIdx]),
        .accessWay (accessWay),
        .victimWay (victimWay),
        .plruOut   (plruNext)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (flushIn || flushPending) stateNext = FLUSH;
                       else if (cpu_reqValidIn)     stateNext = LOOKUP;
            LOOKUP:    stateNext = hit ? IDLE : MISS_REQ;
            MISS_REQ:  if (mem_reqReadyIn) stateNext = MISS_WAIT;
            MISS_WAIT: if (rspMatch) stateNext = FILL;
            FILL:      stateNext = IDLE;
            FLUSH:     stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state             <= IDLE;
            reqAddr           <= '0;
            flushPending      <= 1'b0;
            cpu_rspValidOut   <= 1'b0;
            cpu_rspAddrOut    <= '0;
            cpu_rspInsLineOut <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                validArr[s] <= '0;
                plruArr[s]  <= '0;
            end
        end else begin
            state           <= stateNext;
            cpu_rspValidOut <= 1'b0;
            if (cpu_reqValidIn && cpu_reqReadyOut) reqAddr <= cpu_reqAddrIn;
            if (flushIn && (state != IDLE) && (state != FLUSH)) flushPending <= 1'b1;
            case (state)
                LOOKUP: if (hit) begin
                    cpu_rspValidOut   <= 1'b1;
                    cpu_rspAddrOut    <= reqAddr;
                    cpu_rspInsLineOut <= dataArr[setIdx][hitWay];
                    plruArr[setIdx]   <= plruNext;
                end
                FILL: begin
                    validArr[setIdx][victimWay] <= 1'b1;
                    plruArr[setIdx]             <= plruNext;
                    cpu_rspValidOut             <= 1'b1;
                    cpu_rspAddrOut              <= reqAddr;
                    cpu_rspInsLineOut           <= fillLine;
                end
                FLUSH: begin
                    flushPending <= 1'b0;
                    for (int s = 0; s < NUM_SETS; s++) begin
                        validArr[s] <= '0;
                        plruArr[s]  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage carry no reset; the valid bits qualify them.
    always_ff @(posedge Clock) begin
        if ((state == MISS_WAIT) && rspMatch) fillLine <= mem_rspInsLineIn;
        if (state == FILL) begin
            tagArr[setIdx][victimWay]  <= reqTag;
            dataArr[setIdx][victimWay] <= fillLine;
        end
    end

`ifdef IFU_CACHE_PERF_CNT_EN
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            hitCntOut  <= '0;
            missCntOut <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hitCntOut != '1) hitCntOut <= hitCntOut + 32'd1;
            end else begin
                if (missCntOut != '1) missCntOut <= missCntOut + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ifu_assoc_cache.md
IFU_ASSOC_CACHE -- requirements
Module: ifu_assoc_cache

Interface
REQ-001 SHALL have parameter NUM_WAYS, 4, ways per set; power of two, 2 to 16.
REQ-002 SHALL have parameter NUM_SETS, 4, number of sets; power of two, at least 1.
REQ-003 SHALL have parameter LINE_WIDTH, 128, line width in bits; OFFSET_W = log2(LINE_WIDTH/8).
REQ-004 SHALL have parameter ADDR_WIDTH, 32, byte address width; LADDR_W = ADDR_WIDTH-OFFSET_W.
REQ-005 SHALL have ports:
  Clock, input, 1, sole clock, rising edge.
  Rst, input, 1, asynchronous active-low reset.
  cpu_reqValidIn, input, 1, fetch request valid.
  cpu_reqAddrIn, input, ADDR_WIDTH, fetch byte address.
  cpu_reqReadyOut, output, 1, request accepted when valid and ready.
  cpu_rspValidOut, output, 1, one-cycle response pulse.
  cpu_rspAddrOut, output, ADDR_WIDTH, address of the accepted request.
  cpu_rspInsLineOut, output, LINE_WIDTH, instruction line.
  mem_reqValidOut, output, 1, line fill request.
  mem_reqLineAddrOut, output, LADDR_W, line address requested.
  mem_reqReadyIn, input, 1, memory accepts the request.
  mem_rspValidIn, input, 1, fill data valid.
  mem_rspLineAddrIn, input, LADDR_W, line address of the fill.
  mem_rspInsLineIn, input, LINE_WIDTH, fill data.
  flushIn, input, 1, invalidate the whole cache.
REQ-006 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-007 SHALL decode the address as index = addr[OFFSET_W +: log2(NUM_SETS)] and tag = the remaining upper bits.
REQ-008 SHALL assert cpu_reqReadyOut only in IDLE with flushIn low.
REQ-009 SHALL implement the FSM IDLE -> LOOKUP -> (hit) IDLE or (miss) MISS_REQ -> MISS_WAIT -> FILL -> IDLE, plus FLUSH.
REQ-010 SHALL register the request on accept, compare tags against all valid ways in LOOKUP, and use only the fill path on a miss.
REQ-011 SHALL, on a hit, assert cpu_rspValidOut, cpu_rspAddrOut and the line for exactly one cycle, two cycles after the accept edge; no memory request is issued.
REQ-012 SHALL, in MISS_REQ, hold mem_reqValidOut high with a stable line address until mem_reqReadyIn is high, then enter MISS_WAIT.
REQ-013 SHALL, in MISS_WAIT, ignore mem_rspValidIn unless mem_rspLineAddrIn equals the requested line address.
REQ-014 SHALL, on a matching response, write the line, tag and valid bit to the victim way in FILL, then pulse cpu_rspValidOut with the fill data on the next cycle.
REQ-015 SHALL select the victim as the lowest-index invalid way; if all ways are valid, the tree-PLRU victim of that set.
REQ-016 SHALL keep a tree-PLRU of NUM_WAYS-1 bits per set; node 0 = root, children of node n are 2n+1 and 2n+2; bit 0 points the victim to the lower half; on a hit or fill, every node on the path is set to point away from the accessed way.
REQ-017 SHALL make FLUSH, entered from IDLE when flushIn is high, last one cycle; it clears all valid bits and PLRU bits; flushIn takes priority over a simultaneous request.
REQ-018 SHALL latch a flushIn asserted outside IDLE and execute it after the current transaction completes.
REQ-019 SHALL hold cpu_rspValidOut and mem_reqValidOut low in every state except those stated above.

Reset
REQ-020 SHALL, on Rst low at any time (including mid-miss), immediately return the FSM to IDLE, clear valid bits, PLRU bits, latched flush, all valid outputs and address outputs; the data and tag arrays are not reset.
REQ-021 SHALL raise cpu_reqReadyOut in the first cycle after Rst deasserts.

Configuration
REQ-022 SHALL, with IFU_CACHE_PERF_CNT_EN defined, add 32-bit outputs hitCntOut and missCntOut, incremented in LOOKUP, saturating at all-ones, cleared only by reset; without the macro these ports and counters SHALL be absent.

Structure
REQ-023 SHALL place parameter defaults, OFFSET_W/LADDR_W localparams and the FSM state enum typedef in ifu_pkg.
REQ-024 SHALL implement victim selection and PLRU update as a combinational sub-module ifu_plru_tree, parametrised by NUM_WAYS and instantiated once on the indexed set.

Verification (NUM_WAYS=4, NUM_SETS=4, LINE_WIDTH=128)
REQ-025 SHALL cover reset: assert Rst low mid-MISS_WAIT -> all valid outputs are 0, and ready=1 in the first cycle after release.
REQ-026 SHALL cover miss then hit: request 0x1000 -> mem_reqLineAddrOut=0x100; fill 0xDEADBEEF x4 -> response with that line; request 0x1000 again -> response two cycles after accept, with no mem request.
REQ-027 SHALL cover PLRU: fill 0x000, 0x040, 0x080, 0xC0 (set 0, ways 0-3), hit 0x000, then miss 0x100 -> it evicts way 2 (0x080); re-requesting 0x080 misses and 0x000 hits.
REQ-028 SHALL cover the mismatched fill: during the miss for 0x1000, a response with line address 0x200 is ignored and mem_reqValidOut stays low; the later 0x100 response completes the miss.
REQ-029 SHALL cover flush: after 0x1000 is cached, pulse flushIn together with a request -> request not accepted; the next request to 0x1000 misses.
REQ-030 SHALL cover counters, with the macro defined: after REQ-026, hitCntOut=1 and missCntOut=1; without the macro the bench compiles without those ports.
